// File: rtl/com_loader.sv
// Serial-to-memory loader: parses framed byte streams and drives the processor's
// external-load port while the processor clock is gated.
module com_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 1000000,
    parameter int          TW        = 20
) (
    input  logic        clk1,
    input  logic        RstNot,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        ComENNot,
    output logic [15:0] AddFromCom,
    output logic [15:0] DatFromCom,
    output logic        WriteFromCom,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_CNT_H,
        S_CNT_L,
        S_DAT_H,
        S_DAT_L,
        S_DONE
    } state_t;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        next_state;
    logic [15:0]   addr;
    logic [15:0]   cnt;
    logic [7:0]    hi;
    logic [TW-1:0] tcnt;

    logic ld_addr_h;
    logic ld_addr_l;
    logic ld_cnt_h;
    logic ld_cnt_l;
    logic ld_hi;
    logic wr_word;
    logic t_clear;
    logic t_tick;
    logic done_set;
    logic err_set;

    always_ff @(posedge clk1 or negedge RstNot) begin
        if (!RstNot) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        ld_addr_h  = 1'b0;
        ld_addr_l  = 1'b0;
        ld_cnt_h   = 1'b0;
        ld_cnt_l   = 1'b0;
        ld_hi      = 1'b0;
        wr_word    = 1'b0;
        t_clear    = 1'b0;
        t_tick     = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                t_clear = 1'b1;
                if (RxValid && RxData == SYNC_BYTE) next_state = S_ADDR_H;
            end
            S_DONE: begin
                t_clear    = 1'b1;
                done_set   = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                if (RxValid) begin
                    t_clear = 1'b1;
                    case (state)
                        S_ADDR_H: begin ld_addr_h = 1'b1; next_state = S_ADDR_L; end
                        S_ADDR_L: begin ld_addr_l = 1'b1; next_state = S_CNT_H;  end
                        S_CNT_H:  begin ld_cnt_h  = 1'b1; next_state = S_CNT_L;  end
                        S_CNT_L: begin
                            ld_cnt_l   = 1'b1;
                            next_state = ({cnt[15:8], RxData} == 16'd0) ? S_DONE : S_DAT_H;
                        end
                        S_DAT_H: begin ld_hi = 1'b1; next_state = S_DAT_L; end
                        S_DAT_L: begin
                            wr_word    = 1'b1;
                            next_state = (cnt == 16'd1) ? S_DONE : S_DAT_H;
                        end
                        default: next_state = S_IDLE;
                    endcase
                end else if (tcnt == T_LAST) begin
                    // Silence ran out mid-frame: drop any half word, release the processor.
                    err_set    = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    t_tick = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge RstNot) begin
        if (!RstNot) begin
            addr         <= 16'd0;
            cnt          <= 16'd0;
            tcnt         <= '0;
            AddFromCom   <= 16'd0;
            DatFromCom   <= 16'd0;
            WriteFromCom <= 1'b0;
            Done         <= 1'b0;
            Err          <= 1'b0;
        end else begin
            if (ld_addr_h) addr[15:8] <= RxData;
            if (ld_addr_l) addr[7:0]  <= RxData;
            if (ld_cnt_h)  cnt[15:8]  <= RxData;
            if (ld_cnt_l)  cnt[7:0]   <= RxData;
            if (wr_word) begin
                AddFromCom <= addr;
                DatFromCom <= {hi, RxData};
                addr       <= addr + 16'd1;
                cnt        <= cnt - 16'd1;
            end
            if (t_clear)     tcnt <= '0;
            else if (t_tick) tcnt <= tcnt + 1'b1;
            WriteFromCom <= wr_word;
            Done         <= done_set;
            Err          <= err_set;
        end
    end

    always_ff @(posedge clk1) begin
        if (ld_hi) hi <= RxData;
    end

    // The DONE cycle still counts as busy, so release comes one cycle after the last write.
    assign ComENNot = (state == S_IDLE);
    assign Busy     = (state != S_IDLE);

endmodule

// File: tb/tb_com_loader.sv
// Directed bench for com_loader: a byte-position frame model is checked every cycle,
// plus per-scenario literal expectations on writes, pulses and load-enable duration.
module tb_com_loader;

    localparam int TO = 50;

    logic        clk1 = 1'b0;
    logic        RstNot = 1'b0;
    logic [7:0]  RxData = 8'h00;
    logic        RxValid = 1'b0;
    logic        ComENNot;
    logic [15:0] AddFromCom;
    logic [15:0] DatFromCom;
    logic        WriteFromCom;
    logic        Busy;
    logic        Done;
    logic        Err;

    com_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(TO), .TW(8)) dut (
        .clk1(clk1), .RstNot(RstNot), .RxData(RxData), .RxValid(RxValid),
        .ComENNot(ComENNot), .AddFromCom(AddFromCom), .DatFromCom(DatFromCom),
        .WriteFromCom(WriteFromCom), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 clk1 = ~clk1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scenario statistics gathered by the monitor
    logic [31:0] wr_q[$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int low_cnt  = 0;
    int err_cyc  = 0;
    int acc_cyc  = 0;

    // Frame model: tracks position inside the frame rather than any parser state.
    int          mode = 0;   // 0 idle, 1 receiving, 2 closing cycle
    int          nb = 0;
    int          idle = 0;
    logic [15:0] base = 16'h0;
    logic [15:0] cntm = 16'h0;
    logic [7:0]  mhi = 8'h0;
    logic        e_com = 1'b1, e_busy = 1'b0, e_wr = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [15:0] e_add = 16'h0, e_dat = 16'h0;

    always @(negedge clk1) begin
        if (!RstNot) begin
            mode = 0; e_com = 1'b1; e_busy = 1'b0; e_wr = 1'b0; e_done = 1'b0;
            e_err = 1'b0; e_add = 16'h0; e_dat = 16'h0;
        end
        chk("ComENNot", 32'(ComENNot), 32'(e_com));
        chk("Busy", 32'(Busy), 32'(e_busy));
        chk("WriteFromCom", 32'(WriteFromCom), 32'(e_wr));
        chk("AddFromCom", 32'(AddFromCom), 32'(e_add));
        chk("DatFromCom", 32'(DatFromCom), 32'(e_dat));
        chk("Done", 32'(Done), 32'(e_done));
        chk("Err", 32'(Err), 32'(e_err));
        if (WriteFromCom) wr_q.push_back({AddFromCom, DatFromCom});
        if (Done) done_cnt++;
        if (Err) begin err_cnt++; err_cyc = cyc; end
        if (!ComENNot) low_cnt++;
        if (RstNot) begin
            e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0;
            case (mode)
                0: if (RxValid && RxData == 8'hA5) begin mode = 1; nb = 0; idle = 0; end
                2: begin mode = 0; e_done = 1'b1; end
                default: begin
                    if (RxValid) begin
                        idle = 0;
                        nb++;
                        if (nb == 1) base[15:8] = RxData;
                        else if (nb == 2) base[7:0] = RxData;
                        else if (nb == 3) cntm[15:8] = RxData;
                        else if (nb == 4) begin
                            cntm[7:0] = RxData;
                            if (cntm == 16'h0) mode = 2;
                        end else if ((nb - 5) % 2 == 0) begin
                            mhi = RxData;
                        end else begin
                            e_wr  = 1'b1;
                            e_add = base + 16'((nb - 5) / 2);
                            e_dat = {mhi, RxData};
                            if ((nb - 5) / 2 + 1 == int'(cntm)) mode = 2;
                        end
                    end else begin
                        idle++;
                        if (idle == TO) begin mode = 0; e_err = 1'b1; end
                    end
                end
            endcase
            e_com  = (mode == 0);
            e_busy = (mode != 0);
        end
    end

    task automatic clr_stats();
        wr_q.delete();
        done_cnt = 0; err_cnt = 0; low_cnt = 0; err_cyc = 0;
    endtask

    // Entered and left at posedge+1; gap = idle cycles after the byte.
    task automatic send(input logic [7:0] b, input int gap);
        RxValid = 1'b1;
        RxData  = b;
        @(posedge clk1);
        #1;
        acc_cyc = cyc;
        RxValid = 1'b0;
        repeat (gap) begin @(posedge clk1); #1; end
    endtask

    task automatic send_list(input logic [7:0] bl[$], input int gap, input int tail);
        for (int i = 0; i < bl.size(); i++) send(bl[i], (i == bl.size() - 1) ? tail : gap);
    endtask

    initial begin
        // 1: reset then idle
        repeat (3) @(posedge clk1);
        #1 RstNot = 1'b1;
        chk("rst_comen", 32'(ComENNot), 32'h1);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_add", 32'(AddFromCom), 32'h0);
        repeat (100) begin @(posedge clk1); #1; end
        chk("idle_low_cnt", 32'(low_cnt), 32'd0);
        chk("idle_writes", 32'(wr_q.size()), 32'd0);

        // 2: basic load
        clr_stats();
        send_list('{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 20, 20);
        chk("basic_nwr", 32'(wr_q.size()), 32'd2);
        chk("basic_wr0", wr_q[0], 32'h0010_1234);
        chk("basic_wr1", wr_q[1], 32'h0011_ABCD);
        chk("basic_done", 32'(done_cnt), 32'd1);
        chk("basic_low", 32'(low_cnt), 32'd169);

        // 3: noise and zero count
        clr_stats();
        send_list('{8'h3C, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 10);
        chk("zero_nwr", 32'(wr_q.size()), 32'd0);
        chk("zero_done", 32'(done_cnt), 32'd1);
        chk("zero_low", 32'(low_cnt), 32'd13);

        // 4: wrap and back-to-back
        clr_stats();
        send_list('{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44}, 0, 5);
        chk("wrap_nwr", 32'(wr_q.size()), 32'd2);
        chk("wrap_wr0", wr_q[0], 32'hFFFF_1122);
        chk("wrap_wr1", wr_q[1], 32'h0000_3344);
        chk("wrap_done", 32'(done_cnt), 32'd1);
        chk("wrap_low", 32'(low_cnt), 32'd9);

        // 5: timeout, then recovery frame
        clr_stats();
        send_list('{8'hA5, 8'h00, 8'h20, 8'h00, 8'h03, 8'h11}, 0, TO + 10);
        chk("to_err", 32'(err_cnt), 32'd1);
        chk("to_delay", 32'(err_cyc - acc_cyc), 32'd50);
        chk("to_nwr", 32'(wr_q.size()), 32'd0);
        chk("to_done", 32'(done_cnt), 32'd0);
        chk("to_comen", 32'(ComENNot), 32'h1);
        clr_stats();
        send_list('{8'hA5, 8'h00, 8'h40, 8'h00, 8'h01, 8'hBE, 8'hEF}, 1, 5);
        chk("rec_nwr", 32'(wr_q.size()), 32'd1);
        chk("rec_wr0", wr_q[0], 32'h0040_BEEF);
        chk("rec_done", 32'(done_cnt), 32'd1);

        // 6: reset during the low data byte of word 1
        clr_stats();
        send_list('{8'hA5, 8'h00, 8'h50, 8'h00, 8'h02, 8'hDE}, 1, 1);
        RxValid = 1'b1;
        RxData  = 8'hAD;
        RstNot  = 1'b0;
        #1;
        chk("mrst_wr", 32'(WriteFromCom), 32'h0);
        chk("mrst_comen", 32'(ComENNot), 32'h1);
        chk("mrst_busy", 32'(Busy), 32'h0);
        chk("mrst_add", 32'(AddFromCom), 32'h0);
        @(posedge clk1);
        #1 RxValid = 1'b0;
        repeat (2) @(posedge clk1);
        #1 RstNot = 1'b1;
        repeat (10) begin @(posedge clk1); #1; end
        chk("mrst_nwr", 32'(wr_q.size()), 32'd0);
        chk("mrst_done", 32'(done_cnt), 32'd0);
        chk("mrst_err", 32'(err_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/com_loader.md
Name: com_loader

Overview:
- Upstream feeder of the processor's external-load port.
- Takes a byte stream from the serial receiver and assembles framed program/data words.
- Drives ComENNot, AddFromCom, DatFromCom and WriteFromCom so the host computer can fill memory while the processor clock is gated.
- Reports progress and errors to the board (Busy, Done, Err).

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT, 1000000, idle clk1 cycles allowed between bytes inside a frame before abort.
TW, 20, width of the timeout counter (must hold TIMEOUT).

Ports:
clk1  input  1  system clock, all state on rising edge
RstNot  input  1  asynchronous active-low reset
RxData  input  8  received byte, valid when RxValid=1
RxValid  input  1  one-cycle strobe per received byte
ComENNot  output  1  active-low load enable; 0 = processor clock gated, memory owned by loader
AddFromCom  output  16  memory write address
DatFromCom  output  16  memory write data
WriteFromCom  output  1  one-cycle write strobe
Busy  output  1  1 while a frame is in progress
Done  output  1  one-cycle pulse after last word written
Err  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, RstNot=0):
  - State IDLE; ComENNot=1; AddFromCom=0; DatFromCom=0; WriteFromCom=0; Busy=0; Done=0; Err=0.
  - Word counter and timeout counter cleared.
- Frame format (bytes, MSB first): SYNC_BYTE, ADDR_H, ADDR_L, CNT_H, CNT_L, then CNT words of DAT_H, DAT_L.
- States: IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DAT_H, DAT_L, DONE.
- IDLE:
  - RxValid with RxData==SYNC_BYTE -> ADDR_H; ComENNot=0 and Busy=1 from the next cycle.
  - Any other byte is ignored.
- ADDR_H/ADDR_L:
  - Each accepted byte loads the corresponding half of an internal address register.
  - AddFromCom does not change until the first write.
- CNT_H/CNT_L: load the 16-bit count.
  - On CNT_L: count==0 -> DONE; otherwise -> DAT_H.
- DAT_H: latch the high byte -> DAT_L.
- DAT_L, when the low byte is accepted (edge k):
  - At edge k, AddFromCom <= current address and DatFromCom <= {hi, lo}.
  - WriteFromCom=1 for exactly the cycle after edge k; Add/Dat are stable during that cycle and held until the next write.
  - Address register increments mod 2^16 (0xFFFF wraps to 0x0000, no error). Count decrements.
  - Next state: DONE if the decremented count==0, else DAT_H.
- A byte arriving in the cycle a write strobe is high is accepted normally; no byte is ever dropped.
- DONE (one cycle):
  - ComENNot stays 0 and Busy stays 1, so the processor is not released in the same cycle as the last write.
  - Next edge: state IDLE, ComENNot=1, Busy=0, Done=1 for one cycle.
- Timeout:
  - Counter cleared on every accepted byte and in IDLE; increments each cycle in any non-IDLE, non-DONE state.
  - Reaching TIMEOUT: -> IDLE, ComENNot=1, Busy=0, Err=1 for one cycle, no write issued.
  - A partially received word is discarded. Already-written words stay written.
- A SYNC_BYTE value received mid-frame is treated as data, not as a restart.
- Reset mid-frame: immediate abort to reset values; a pending WriteFromCom is cancelled asynchronously.
- Done and Err are never asserted in the same cycle.

Test Plan:
1. Reset then idle: hold RstNot=0 for 3 cycles, release, no bytes -> all outputs at reset values for 100 cycles.
2. Basic load: bytes A5,00,10,00,02,12,34,AB,CD, spaced 20 cycles apart.
   - Two WriteFromCom pulses: (0x0010, 0x1234) then (0x0011, 0xABCD).
   - ComENNot low from the cycle after A5 until the cycle after DONE; Done pulses once.
3. Noise and zero count: bytes 3C,FF,A5,00,00,00,00.
   - The first two bytes are ignored.
   - No write strobes; Done pulses; ComENNot low for exactly the header duration plus the DONE cycle.
4. Wrap and back-to-back: frame at address FFFF with count 2, data bytes on consecutive cycles.
   - Writes go to 0xFFFF then 0x0000; no byte lost when RxValid coincides with WriteFromCom.
5. Timeout: TIMEOUT=50; send A5,00,20,00,03,11 then silence.
   - Err pulse exactly 50 cycles after the byte 11; no write; ComENNot=1; a following valid frame loads correctly.
6. Reset mid-frame: assert RstNot=0 during the DAT_L byte of word 1.
   - Outputs return immediately to reset values; no WriteFromCom pulse appears.
